// File: rtl/vga_cursor_ctrl.sv
// Text-mode cursor sequencer: merges CPU byte writes to the cursor status word with
// relative/absolute move commands, tracks row/col, and generates the blink clock.
module vga_cursor_ctrl #(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int BLINK_HALF = 25000000,
    parameter int POS_W      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cpu_we,
    input  logic [31:0]      cpu_data,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_op,
    input  logic [POS_W-1:0] cmd_pos,
    output logic             cmd_ready,
    output logic [3:0]       cur_we,
    output logic [31:0]      cur_data,
    output logic             clk_cursor,
    output logic [POS_W-1:0] pos,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [POS_W-1:0] COLS_P   = POS_W'(COLS);
    localparam logic [POS_W-1:0] CELLS_P  = POS_W'(COLS * ROWS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_RIGHT = 3'd1;
    localparam logic [2:0] OP_LEFT  = 3'd2;
    localparam logic [2:0] OP_DOWN  = 3'd3;
    localparam logic [2:0] OP_UP    = 3'd4;
    localparam logic [2:0] OP_CR    = 3'd5;
    localparam logic [2:0] OP_HOME  = 3'd6;
    localparam logic [2:0] OP_SET   = 3'd7;

    typedef enum logic [1:0] {IDLE, DECOMP, CALC, ISSUE} state_t;

    state_t             state;
    logic [2:0]         op;
    logic [31:0]        shadow;
    logic [31:0]        shadow_next;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [POS_W-1:0]   rem;
    logic [BLK_W-1:0]   blink_cnt;
    logic               resync;
    logic [POS_W-1:0]   lin;
    logic [ROW_W-1:0]   row_inc;
    logic [ROW_W-1:0]   row_dec;

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
    // are both high; cmd_ready never depends on cmd_valid.
    assign cmd_ready = (state == IDLE) && (cpu_we == 4'b0000) && !resync;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_comb begin
        shadow_next = shadow;
        for (int i = 0; i < 4; i++) begin
            if (cpu_we[i]) shadow_next[8*i +: 8] = cpu_data[8*i +: 8];
        end
    end

    assign lin     = POS_W'(row) * COLS_P + POS_W'(col);
    assign row_inc = (row == ROW_LAST) ? '0 : row + ROW_ONE;
    assign row_dec = (row == '0) ? ROW_LAST : row - ROW_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            op         <= OP_NOP;
            shadow     <= '0;
            row        <= '0;
            col        <= '0;
            rem        <= '0;
            pos        <= '0;
            cur_we     <= '0;
            cur_data   <= '0;
            clk_cursor <= 1'b1;
            blink_cnt  <= '0;
            resync     <= 1'b0;
        end else begin
            cur_we <= '0;
            if (cpu_we != 4'b0000) begin
                shadow   <= shadow_next;
                cur_we   <= cpu_we;
                cur_data <= shadow_next;
            end

            if (blink_cnt == BLK_LAST) begin
                blink_cnt  <= '0;
                clk_cursor <= ~clk_cursor;
            end else begin
                blink_cnt <= blink_cnt + BLK_ONE;
            end

            case (state)
                IDLE: begin
                    if (resync) begin
                        state <= DECOMP;
                        op    <= OP_NOP;
                        row   <= '0;
                        rem   <= shadow_next[POS_W-1:0];
                    end else if (cmd_valid && cmd_ready) begin
                        op <= cmd_op;
                        if (cmd_op == OP_SET) begin
                            state <= DECOMP;
                            row   <= '0;
                            rem   <= (cmd_pos >= CELLS_P) ? '0 : cmd_pos;
                        end else if (cmd_op != OP_NOP) begin
                            state <= CALC;
                        end
                    end
                end
                DECOMP: begin
                    // A new CPU position always wins over whatever was being decomposed.
                    if (cpu_we[1:0] != 2'b00) begin
                        op  <= OP_NOP;
                        row <= '0;
                        rem <= shadow_next[POS_W-1:0];
                    end else if (rem >= COLS_P && row != ROW_LAST) begin
                        rem <= rem - COLS_P;
                        row <= row + ROW_ONE;
                    end else begin
                        if (rem >= COLS_P) begin
                            row <= '0;
                            col <= '0;
                        end else begin
                            col <= rem[COL_W-1:0];
                        end
                        state  <= (op == OP_SET) ? ISSUE : IDLE;
                        resync <= 1'b0;
                    end
                end
                CALC: begin
                    case (op)
                        OP_RIGHT: begin
                            if (col == COL_LAST) begin
                                col <= '0;
                                row <= row_inc;
                            end else begin
                                col <= col + COL_ONE;
                            end
                        end
                        OP_LEFT: begin
                            if (col == '0) begin
                                col <= COL_LAST;
                                row <= row_dec;
                            end else begin
                                col <= col - COL_ONE;
                            end
                        end
                        OP_DOWN: row <= row_inc;
                        OP_UP:   row <= row_dec;
                        OP_CR:   col <= '0;
                        OP_HOME: begin
                            row <= '0;
                            col <= '0;
                        end
                        default: ;
                    endcase
                    state <= ISSUE;
                end
                ISSUE: begin
                    pos <= lin;
                    // A concurrent CPU write goes out this cycle; the position follows next.
                    if (cpu_we == 4'b0000) begin
                        shadow[POS_W-1:0] <= lin;
                        cur_we            <= 4'b0011;
                        cur_data          <= {shadow[31:POS_W], lin};
                        resync            <= 1'b0;
                        blink_cnt         <= '0;
                        clk_cursor        <= 1'b1;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (cpu_we[1:0] != 2'b00) resync <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_cursor_ctrl.sv
// Bench for vga_cursor_ctrl: command vector table, CPU/command interleaving,
// blink timing and reset abort, with a scoreboard of expected register writes.
module tb_vga_cursor_ctrl;

    localparam int BH = 4;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_RIGHT = 3'd1;
    localparam logic [2:0] OP_LEFT  = 3'd2;
    localparam logic [2:0] OP_DOWN  = 3'd3;
    localparam logic [2:0] OP_UP    = 3'd4;
    localparam logic [2:0] OP_CR    = 3'd5;
    localparam logic [2:0] OP_HOME  = 3'd6;
    localparam logic [2:0] OP_SET   = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  cpu_we = '0;
    logic [31:0] cpu_data = '0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [10:0] cmd_pos = '0;
    logic        cmd_ready;
    logic [3:0]  cur_we;
    logic [31:0] cur_data;
    logic        clk_cursor;
    logic [10:0] pos;
    logic        busy;
    logic [1:0]  fsm_state;

    vga_cursor_ctrl #(.COLS(40), .ROWS(30), .BLINK_HALF(BH), .POS_W(11)) dut (
        .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_data(cpu_data),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_pos(cmd_pos),
        .cmd_ready(cmd_ready), .cur_we(cur_we), .cur_data(cur_data),
        .clk_cursor(clk_cursor), .pos(pos), .busy(busy), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] exp_q[$];
    logic [35:0] mon_e;
    logic [31:0] tb_shadow = '0;

    typedef struct {
        logic [2:0]  op;
        logic [10:0] p;
        logic [10:0] exp;
        int          lat;
    } vec_t;
    vec_t vt[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every register write must match the head of the queue
    always @(negedge clk) begin
        if (rst && cur_we != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {28'h0, cur_we, cur_data}, 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("write", {28'h0, cur_we, cur_data}, {28'h0, mon_e});
            end
        end
    end

    // drivers
    task automatic push_cmd(input logic [10:0] p);
        tb_shadow[10:0] = p;
        exp_q.push_back({4'b0011, tb_shadow});
    endtask

    task automatic push_cpu(input logic [3:0] we, input logic [31:0] d);
        for (int i = 0; i < 4; i++) if (we[i]) tb_shadow[8*i +: 8] = d[8*i +: 8];
        exp_q.push_back({we, tb_shadow});
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [10:0] p);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_pos   = p;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", {63'h0, cmd_ready}, 64'h1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic cpu_write(input logic [3:0] we, input logic [31:0] d);
        push_cpu(we, d);
        @(negedge clk);
        cpu_we   = we;
        cpu_data = d;
        @(posedge clk);
        #1 cpu_we = '0;
    endtask

    task automatic measure(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cur_we == 4'b0000 && n < 100);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 300);
        check("ready_timeout", {63'h0, cmd_ready}, 64'h1);
    endtask

    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [10:0] p,
                          input logic [10:0] exp, input int lat);
        int n;
        if (lat != 0) push_cmd(exp);
        send_cmd(op, p);
        if (lat != 0) begin
            measure(n);
            check({tag, "_latency"}, 64'(n), 64'(lat));
        end else begin
            repeat (3) @(negedge clk);
            check({tag, "_nop_busy"}, {63'h0, busy}, 64'h0);
        end
        wait_ready();
        @(negedge clk);
        check({tag, "_pos"}, {53'h0, pos}, {53'h0, exp});
        check({tag, "_queue"}, 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int m;
        logic prev;

        vt[0]  = '{OP_SET,   11'd1199, 11'd1199, 32};
        vt[1]  = '{OP_RIGHT, 11'd0,    11'd0,    3};
        vt[2]  = '{OP_LEFT,  11'd0,    11'd1199, 3};
        vt[3]  = '{OP_UP,    11'd0,    11'd1159, 3};
        vt[4]  = '{OP_DOWN,  11'd0,    11'd1199, 3};
        vt[5]  = '{OP_CR,    11'd0,    11'd1160, 3};
        vt[6]  = '{OP_HOME,  11'd0,    11'd0,    3};
        vt[7]  = '{OP_UP,    11'd0,    11'd1160, 3};
        vt[8]  = '{OP_LEFT,  11'd0,    11'd1159, 3};
        vt[9]  = '{OP_NOP,   11'd0,    11'd1159, 0};
        vt[10] = '{OP_SET,   11'd1300, 11'd0,    3};
        vt[11] = '{OP_SET,   11'd85,   11'd85,   5};
        vt[12] = '{OP_DOWN,  11'd0,    11'd125,  3};
        vt[13] = '{OP_CR,    11'd0,    11'd120,  3};
        vt[14] = '{OP_LEFT,  11'd0,    11'd119,  3};
        vt[15] = '{OP_RIGHT, 11'd0,    11'd120,  3};
        vt[16] = '{OP_SET,   11'd39,   11'd39,   3};
        vt[17] = '{OP_RIGHT, 11'd0,    11'd40,   3};
        vt[18] = '{OP_SET,   11'd1200, 11'd0,    3};
        vt[19] = '{OP_LEFT,  11'd0,    11'd1199, 3};

        // reset
        repeat (3) @(negedge clk);
        check("rst_cur_we", {60'h0, cur_we}, 64'h0);
        check("rst_pos", {53'h0, pos}, 64'h0);
        check("rst_clk_cursor", {63'h0, clk_cursor}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", {63'h0, cmd_ready}, 64'h1);
        check("rel_busy", {63'h0, busy}, 64'h0);
        check("rel_cur_data", {32'h0, cur_data}, 64'h0);
        check("rel_clk_cursor", {63'h0, clk_cursor}, 64'h1);

        for (int i = 0; i < 20; i++) begin
            do_cmd($sformatf("vec%0d", i), vt[i].op, vt[i].p, vt[i].exp, vt[i].lat);
        end

        // CPU position write triggers a resync decomposition: 81 -> row 2, col 1
        cpu_write(4'b0011, 32'h0300_0051);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("resync_busy_cycles", 64'(n), 64'd3);
        do_cmd("cpu_down", OP_DOWN, 11'd0, 11'd121, 3);
        do_cmd("cpu_home", OP_HOME, 11'd0, 11'd0, 3);
        do_cmd("cpu_up",   OP_UP,   11'd0, 11'd1160, 3);

        // CPU write landing in ISSUE: CPU pulse first, command pulse next
        do_cmd("set10", OP_SET, 11'd10, 11'd10, 3);
        push_cpu(4'b1000, 32'hAB00_0000);
        push_cmd(11'd9);
        send_cmd(OP_LEFT, 11'd0);
        @(negedge clk);
        @(negedge clk);
        cpu_we   = 4'b1000;
        cpu_data = 32'hAB00_0000;
        @(posedge clk);
        #1 cpu_we = '0;
        @(negedge clk);
        check("stall_cpu_we", {60'h0, cur_we}, 64'h8);
        @(negedge clk);
        check("stall_cmd_we", {60'h0, cur_we}, 64'h3);
        check("stall_cmd_pos", {53'h0, cur_data[10:0]}, 64'd9);
        check("stall_cmd_byte3", {56'h0, cur_data[31:24]}, 64'hAB);
        wait_ready();
        check("stall_pos", {53'h0, pos}, 64'd9);
        check("stall_queue", 64'(exp_q.size()), 64'h0);

        // free-running blink half-period
        prev = clk_cursor;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (clk_cursor == prev && n < 20);
        prev = clk_cursor;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (clk_cursor == prev && m < 20);
        check("blink_period", 64'(m), 64'(BH));

        // command issue restarts the blink phase
        do_cmd("blink_home", OP_HOME, 11'd0, 11'd0, 3);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_cmd(11'(k + 1));
            send_cmd(OP_RIGHT, 11'd0);
            measure(n);
            check("blink_cmd_latency", 64'(n), 64'd3);
            check("blink_forced_high", {63'h0, clk_cursor}, 64'h1);
            m = 0;
            do begin
                @(negedge clk);
                m++;
            end while (clk_cursor == 1'b1 && m < 20);
            check("blink_after_issue", 64'(m), 64'(BH));
            wait_ready();
            check("blink_pos", {53'h0, pos}, 64'(k + 1));
        end

        // out-of-range CPU position decomposes to (0,0)
        cpu_write(4'b0011, 32'h0000_07D0);
        do_cmd("oor_right", OP_RIGHT, 11'd0, 11'd1, 3);

        // reset in the middle of a SET aborts it without a write
        send_cmd(OP_SET, 11'd85);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tb_shadow = '0;
        repeat (2) @(negedge clk);
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_cur_we", {60'h0, cur_we}, 64'h0);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_pos", {53'h0, pos}, 64'h0);
        check("abort_ready", {63'h0, cmd_ready}, 64'h1);
        do_cmd("post_abort", OP_RIGHT, 11'd0, 11'd1, 3);

        repeat (2) @(negedge clk);
        check("final_queue", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
